// File: rtl/ks16_pipe_subtractor_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone subtractor.
// The optional overflow output is enabled by the KS16_SUB_OVF_EN macro.
package ks_sub_pkg;

  // Operand width. Every struct below is sized from it, so it lives here.
  localparam int WIDTH = 16;

  function automatic int levels(input int w);
    return $clog2(w);
  endfunction

  localparam int LEVELS = levels(WIDTH);
  localparam int SPLIT  = LEVELS / 2;

  // Generate/propagate vectors carried through the prefix tree.
  typedef struct packed {
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
  } gp_t;

  // One (G, P) pair, the operand of the prefix combine.
  typedef struct packed {
    logic g;
    logic p;
  } gp_bit_t;

  // Contents of the mid-pipeline register.
  typedef struct packed {
    logic [WIDTH-1:0] p;      // raw per-bit propagate, needed for the sum
    gp_t              gp;     // group G/P after the first SPLIT levels
`ifdef KS16_SUB_OVF_EN
    logic             a_msb;  // minuend sign, needed for signed overflow
`endif
  } s1_payload_t;

  // Contents of the output register.
  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
`ifdef KS16_SUB_OVF_EN
    logic             ovf;
`endif
  } s2_payload_t;

  // (G, P) o (G', P'): higher group absorbs the lower one.
  function automatic gp_bit_t combine(input gp_bit_t hi, input gp_bit_t lo);
    gp_bit_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/ks16_pipe_subtractor_if.sv
// Valid/ready operand and result streams of the pipelined subtractor.
// KS16_SUB_OVF_EN adds the out_ovf result bit.
interface ks16_pipe_subtractor_if;
  import ks_sub_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_borrow;
  logic             out_zero;
`ifdef KS16_SUB_OVF_EN
  logic             out_ovf;
`endif

  // Operand issuer and result consumer side.
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input
`ifdef KS16_SUB_OVF_EN
      out_ovf,
`endif
      in_ready, out_valid, out_diff, out_borrow, out_zero
  );

  // Subtractor side.
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output
`ifdef KS16_SUB_OVF_EN
      out_ovf,
`endif
      in_ready, out_valid, out_diff, out_borrow, out_zero
  );

endinterface

// File: rtl/ks16_pipe_subtractor_prefix_level.sv
// One combinational Kogge-Stone level: every bit at or above DIST merges
// with the group DIST positions below it; lower bits pass through.
module ks_prefix_level
  import ks_sub_pkg::*;
#(
  parameter int DIST = 1
) (
  input  gp_t gp_i,
  output gp_t gp_o
);

  gp_bit_t merged;

  // Combine each bit with its partner DIST positions lower.
  always_comb begin
    // NOTE: full default before the loop so no bit of gp_o can infer a latch.
    gp_o   = gp_i;
    merged = '0;
    for (int i = DIST; i < WIDTH; i++) begin
      merged    = combine('{g: gp_i.g[i], p: gp_i.p[i]},
                          '{g: gp_i.g[i-DIST], p: gp_i.p[i-DIST]});
      gp_o.g[i] = merged.g;
      gp_o.p[i] = merged.p;
    end
  end

endmodule

// File: rtl/ks16_pipe_subtractor.sv
// Two-stage pipelined Kogge-Stone subtractor, A - B = A + ~B + 1, with
// borrow and zero flags behind a fully backpressured valid/ready stream.
// Prefix levels 0..SPLIT-1 sit before the S1 register, the rest before S2.
// KS16_SUB_OVF_EN adds the signed-overflow output out_ovf.
module ks16_pipe_subtractor
  import ks_sub_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  ks16_pipe_subtractor_if.slave bus
);

  logic [WIDTH-1:0] b_inv, g_raw, p_raw, g_fin;
  gp_t              pre_gp  [SPLIT+1];
  gp_t              post_gp [LEVELS-SPLIT+1];
  s1_payload_t      s1_q, s1_d;
  s2_payload_t      s2_q, s2_d, s2_next;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic             s2_adv;
  logic             unused_p;

  // Bit-level generate/propagate; the carry-in of 1 folds into bit 0.
  assign b_inv     = ~bus.in_b;
  assign g_raw     = bus.in_a & b_inv;
  assign p_raw     = bus.in_a ^ b_inv;
  assign pre_gp[0] = '{g: {g_raw[WIDTH-1:1], g_raw[0] | p_raw[0]}, p: p_raw};

  for (genvar k = 0; k < SPLIT; k++) begin : g_lo_level
    ks_prefix_level #(.DIST(1 << k)) u_level (
      .gp_i(pre_gp[k]),
      .gp_o(pre_gp[k+1])
    );
  end

  assign post_gp[0] = s1_q.gp;

  for (genvar k = SPLIT; k < LEVELS; k++) begin : g_hi_level
    ks_prefix_level #(.DIST(1 << k)) u_level (
      .gp_i(post_gp[k-SPLIT]),
      .gp_o(post_gp[k-SPLIT+1])
    );
  end

  // Final group propagates are not part of any result.
  assign unused_p = ^post_gp[LEVELS-SPLIT].p;
  assign g_fin    = post_gp[LEVELS-SPLIT].g;

  // Sum and flags from the completed carries; bit 0 sees the carry-in.
  always_comb begin
    s2_next        = '0;
    s2_next.diff   = s1_q.p ^ {g_fin[WIDTH-2:0], 1'b1};
    s2_next.borrow = ~g_fin[WIDTH-1];
    s2_next.zero   = (s2_next.diff == '0);
`ifdef KS16_SUB_OVF_EN
    // a_msb ^ b_msb equals ~p_msb because p was formed against ~b.
    s2_next.ovf    = ~s1_q.p[WIDTH-1] & (s1_q.a_msb ^ s2_next.diff[WIDTH-1]);
`endif
  end

  // S2 moves when it is empty or being drained; S1 fills whenever it is
  // empty or its contents move into S2.
  assign s2_adv       = ~s2_valid_q | bus.out_ready;
  assign bus.in_ready = ~s2_valid_q | bus.out_ready | ~s1_valid_q;

  // Next-state of both pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (bus.in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_d.p     = p_raw;
        s1_d.gp    = pre_gp[SPLIT];
`ifdef KS16_SUB_OVF_EN
        s1_d.a_msb = bus.in_a[WIDTH-1];
`endif
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) s2_d = s2_next;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      // NOTE: data registers are reset too, so the result outputs read zero
      // straight out of reset rather than whatever the flops powered up with.
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.out_valid  = s2_valid_q;
  assign bus.out_diff   = s2_q.diff;
  assign bus.out_borrow = s2_q.borrow;
  assign bus.out_zero   = s2_q.zero;
`ifdef KS16_SUB_OVF_EN
  assign bus.out_ovf    = s2_q.ovf;
`endif

endmodule
